// File: rtl/risc_pkg.sv
// Shared VeryRISC definitions: opcode values, default memory geometry and
// the program-loader state encoding.
package risc_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RUN_W      = 16;
  localparam int unsigned LEN_W      = 6;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } loader_state_e;

  // An image length must be non-zero and fit in the program memory.
  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input int unsigned depth);
    return (len != '0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/risc_loader_if.sv
// Byte-stream valid/ready port feeding the program loader.
interface risc_loader_if #(
  parameter int unsigned DATA_W = risc_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/risc_loader_sat_counter.sv
// Enable/clear up-counter that stops at LIMIT and flags the step that reaches it.
module sat_counter #(
  parameter int unsigned W     = 16,
  parameter int unsigned LIMIT = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last_c
);

  assign last_c = (count == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/risc_loader.sv
// Streams a length-prefixed image into program memory with the CPU held in
// reset, then releases the CPU and counts clocks until halt or timeout.
module risc_loader
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MAX_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  risc_loader_if.slave      stream,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic              halt,
  output logic              done,
  output logic              timeout,
  output logic              err,
  output logic [RUN_W-1:0]  run_cycles
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  loader_state_e     state, state_next;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              we_d, err_d, done_d, timeout_d, cpu_rst_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              accept;
  logic              cnt_en;
  logic              at_limit;

  assign stream.in_ready = ready_q;
  assign accept          = stream.in_valid && ready_q;

  sat_counter #(
    .W     (RUN_W),
    .LIMIT (MAX_CYCLES)
  ) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .en     (cnt_en),
    .count  (run_cycles),
    .last_c (at_limit)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_next = state;
    len_d      = len_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    err_d      = 1'b0;
    timeout_d  = timeout;
    cnt_en     = 1'b0;

    if (clear) begin
      state_next = ST_IDLE;
      timeout_d  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (len_legal(stream.in_data[LEN_W-1:0], DEPTH)) begin
              state_next = ST_LOAD;
              len_d      = stream.in_data[LEN_W-1:0];
              idx_d      = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(idx_q);
            wdata_d = stream.in_data;
            idx_d   = idx_q + LEN_W'(1);
            if (idx_d == len_q) begin
              state_next = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          state_next = ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            state_next = ST_DONE;
          end else begin
            cnt_en = 1'b1;
            if (at_limit) begin
              state_next = ST_DONE;
              timeout_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    ready_d   = (state_next == ST_IDLE) || (state_next == ST_LOAD);
    done_d    = (state_next == ST_DONE);
    // The CPU leaves reset one clock after RUN is entered, once the last write has landed.
    cpu_rst_d = !((state == ST_RUN) && (state_next == ST_RUN));
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b1;
      cpu_rst   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      len_q     <= len_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      cpu_rst   <= cpu_rst_d;
      // The loader owns the memory port only while the CPU is held in reset.
      mem_we    <= we_d && cpu_rst_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      done      <= done_d;
      timeout   <= timeout_d;
      err       <= err_d;
    end
  end

endmodule
